// File: rtl/j1_wb_arbiter_if.sv
// Bundle of the two J1 master request ports and the Wishbone classic bus.
// "slave" is the arbiter's view; "master" is the view of whoever drives the masters and the WB slave.
interface j1_wb_arbiter_if;
    logic        m0_req,   m1_req;
    logic        m0_we,    m1_we;
    logic [15:0] m0_adr,   m1_adr;
    logic [15:0] m0_dat_w, m1_dat_w;
    logic [15:0] m0_dat_r, m1_dat_r;
    logic        m0_ack,   m1_ack;
    logic        m0_err,   m1_err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [15:0] wb_adr_o, wb_dat_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;
    logic [1:0]  gnt;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_adr, m1_adr, m0_dat_w, m1_dat_w,
        input  wb_dat_i, wb_ack_i,
        output m0_dat_r, m1_dat_r, m0_ack, m1_ack, m0_err, m1_err,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, gnt
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_adr, m1_adr, m0_dat_w, m1_dat_w,
        output wb_dat_i, wb_ack_i,
        input  m0_dat_r, m1_dat_r, m0_ack, m1_ack, m0_err, m1_err,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, gnt
    );
endinterface

// File: rtl/j1_wb_arbiter.sv
// Two-master (J1 data bus, host loader) to one Wishbone classic arbiter, IDLE/BUS/ACK FSM.
// Optional bus timeout with error response is enabled by defining J1_WB_ARB_TIMEOUT_EN.
module j1_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit FIXED_PRIO     = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    j1_wb_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_gnt;
    logic        r_last_m1;
    logic        r_we;
    logic [15:0] r_adr, r_dat_o;
    logic [15:0] r_m0_dat_r, r_m1_dat_r;
    logic [1:0]  w_win;
    logic        w_tmo;
    logic        w_done;
    logic [15:0] w_rdata;

    // Winner among current requesters; a lone requester wins regardless of history.
    always_comb begin
        w_win = 2'b00;
        if (bus.m0_req && bus.m1_req)
            w_win = (FIXED_PRIO || r_last_m1) ? 2'b01 : 2'b10;
        else if (bus.m0_req)
            w_win = 2'b01;
        else if (bus.m1_req)
            w_win = 2'b10;
    end

`ifdef J1_WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_tmo_cnt;
    logic       r_err;

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_tmo_cnt <= 8'd0;
        else if (r_state != BUS)
            r_tmo_cnt <= 8'd0;
        else if (!bus.wb_ack_i)
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end

    // Fires on the edge ending the TIMEOUT_CYCLES-th BUS cycle; a real ack on that edge wins.
    assign w_tmo = (r_state == BUS) && !bus.wb_ack_i && (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_err <= 1'b0;
        else if (w_done)
            r_err <= w_tmo;
        else if (r_state == ACK)
            r_err <= 1'b0;
    end

    assign bus.m0_err = bus.m0_ack && r_err;
    assign bus.m1_err = bus.m1_ack && r_err;
`else
    assign w_tmo      = 1'b0;
    assign bus.m0_err = 1'b0;
    assign bus.m1_err = 1'b0;
`endif

    assign w_done  = (r_state == BUS) && (bus.wb_ack_i || w_tmo);
    assign w_rdata = bus.wb_ack_i ? bus.wb_dat_i : 16'hDEAD;

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|w_win) w_next = BUS;
            BUS:     if (bus.wb_ack_i || w_tmo) w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_gnt      <= 2'b00;
            r_last_m1  <= 1'b1;
            r_we       <= 1'b0;
            r_adr      <= 16'h0000;
            r_dat_o    <= 16'h0000;
            r_m0_dat_r <= 16'h0000;
            r_m1_dat_r <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: if (|w_win) begin
                    r_gnt     <= w_win;
                    r_last_m1 <= w_win[1];
                    r_we      <= w_win[0] ? bus.m0_we    : bus.m1_we;
                    r_adr     <= w_win[0] ? bus.m0_adr   : bus.m1_adr;
                    r_dat_o   <= w_win[0] ? bus.m0_dat_w : bus.m1_dat_w;
                end
                BUS: if (w_done) begin
                    if (r_gnt[0]) r_m0_dat_r <= w_rdata;
                    else          r_m1_dat_r <= w_rdata;
                end
                ACK:     r_gnt <= 2'b00;
                default: r_gnt <= 2'b00;
            endcase
        end
    end

    assign bus.wb_cyc_o = (r_state == BUS);
    assign bus.wb_stb_o = (r_state == BUS);
    assign bus.wb_we_o  = r_we;
    assign bus.wb_adr_o = r_adr;
    assign bus.wb_dat_o = r_dat_o;
    assign bus.gnt      = r_gnt;
    assign bus.m0_ack   = (r_state == ACK) && r_gnt[0];
    assign bus.m1_ack   = (r_state == ACK) && r_gnt[1];
    assign bus.m0_dat_r = r_m0_dat_r;
    assign bus.m1_dat_r = r_m1_dat_r;
endmodule

// File: tb/tb_j1_wb_arbiter.sv
// Directed bench for j1_wb_arbiter: dut0 round robin, dut1 fixed priority, same stimulus.
// Timeout expectations follow J1_WB_ARB_TIMEOUT_EN at compile time.
module tb_j1_wb_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    j1_wb_arbiter_if u_if0 ();
    j1_wb_arbiter_if u_if1 ();

    assign u_if1.m0_req   = u_if0.m0_req;
    assign u_if1.m1_req   = u_if0.m1_req;
    assign u_if1.m0_we    = u_if0.m0_we;
    assign u_if1.m1_we    = u_if0.m1_we;
    assign u_if1.m0_adr   = u_if0.m0_adr;
    assign u_if1.m1_adr   = u_if0.m1_adr;
    assign u_if1.m0_dat_w = u_if0.m0_dat_w;
    assign u_if1.m1_dat_w = u_if0.m1_dat_w;
    assign u_if1.wb_dat_i = u_if0.wb_dat_i;
    assign u_if1.wb_ack_i = u_if0.wb_ack_i;

    j1_wb_arbiter #(.TIMEOUT_CYCLES(4), .FIXED_PRIO(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(u_if0));
    j1_wb_arbiter #(.TIMEOUT_CYCLES(4), .FIXED_PRIO(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(u_if1));

    logic [72:0] outs0;
    assign outs0 = {u_if0.wb_cyc_o, u_if0.wb_stb_o, u_if0.wb_we_o, u_if0.wb_adr_o, u_if0.wb_dat_o,
                    u_if0.gnt, u_if0.m0_ack, u_if0.m1_ack, u_if0.m0_err, u_if0.m1_err,
                    u_if0.m0_dat_r, u_if0.m1_dat_r};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        u_if0.m0_req = 0; u_if0.m1_req = 0; u_if0.m0_we = 0; u_if0.m1_we = 0;
        u_if0.m0_adr = 0; u_if0.m1_adr = 0; u_if0.m0_dat_w = 0; u_if0.m1_dat_w = 0;
        u_if0.wb_dat_i = 0; u_if0.wb_ack_i = 0;
    endtask

    task automatic apply_reset();
        reset_n = 0;
        clear_inputs();
        tick(); tick();
        reset_n = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (outs0 !== 73'd0) begin
            failures++; $display("FAIL reset_outs0 got=%h want=0", outs0);
        end
        checks++;
        if (u_if1.gnt !== 2'b00 || u_if1.wb_cyc_o !== 1'b0) begin
            failures++; $display("FAIL reset_dut1 gnt=%b cyc=%b want 0/0", u_if1.gnt, u_if1.wb_cyc_o);
        end
    endtask

    task automatic test_read();
        apply_reset();
        u_if0.m0_req = 1; u_if0.m0_we = 0; u_if0.m0_adr = 16'h0010;
        tick();
        checks++;
        if ({u_if0.wb_cyc_o, u_if0.wb_stb_o, u_if0.wb_we_o, u_if0.gnt} !== 5'b11001) begin
            failures++; $display("FAIL read_bus cyc/stb/we/gnt=%b want 11001",
                                 {u_if0.wb_cyc_o, u_if0.wb_stb_o, u_if0.wb_we_o, u_if0.gnt});
        end
        checks++;
        if (u_if0.wb_adr_o !== 16'h0010) begin
            failures++; $display("FAIL read_adr got=%h want=0010", u_if0.wb_adr_o);
        end
        u_if0.m0_req = 0; u_if0.wb_ack_i = 1; u_if0.wb_dat_i = 16'h1234;
        tick();
        u_if0.wb_ack_i = 0; u_if0.wb_dat_i = 16'h0000;
        checks++;
        if ({u_if0.m0_ack, u_if0.m1_ack, u_if0.m0_err, u_if0.wb_cyc_o, u_if0.gnt} !== 6'b100001) begin
            failures++; $display("FAIL read_ack ack0/ack1/err/cyc/gnt=%b want 100001",
                                 {u_if0.m0_ack, u_if0.m1_ack, u_if0.m0_err, u_if0.wb_cyc_o, u_if0.gnt});
        end
        checks++;
        if (u_if0.m0_dat_r !== 16'h1234) begin
            failures++; $display("FAIL read_data got=%h want=1234", u_if0.m0_dat_r);
        end
        tick();
        checks++;
        if (u_if0.m0_ack !== 1'b0 || u_if0.gnt !== 2'b00 || u_if0.m0_dat_r !== 16'h1234) begin
            failures++; $display("FAIL read_hold ack=%b gnt=%b dat=%h want 0/00/1234",
                                 u_if0.m0_ack, u_if0.gnt, u_if0.m0_dat_r);
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp0 [4];
        exp0[0] = 2'b01; exp0[1] = 2'b10; exp0[2] = 2'b01; exp0[3] = 2'b10;
        apply_reset();
        u_if0.m0_req = 1; u_if0.m1_req = 1;
        u_if0.m0_adr = 16'h0100; u_if0.m1_adr = 16'h0200;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (u_if0.gnt !== exp0[i]) begin
                failures++; $display("FAIL rr_grant%0d got=%b want=%b", i, u_if0.gnt, exp0[i]);
            end
            checks++;
            if (u_if1.gnt !== 2'b01) begin
                failures++; $display("FAIL fixed_grant%0d got=%b want=01", i, u_if1.gnt);
            end
            u_if0.wb_ack_i = 1;
            tick();
            u_if0.wb_ack_i = 0;
            tick();
        end
        u_if0.m0_req = 0; u_if0.m1_req = 0;
        tick();
    endtask

    task automatic test_back_to_back_write();
        int bad;
        apply_reset();
        // a stray slave ack while idle must not move the FSM
        u_if0.wb_ack_i = 1;
        tick();
        u_if0.wb_ack_i = 0;
        checks++;
        if (outs0 !== 73'd0) begin
            failures++; $display("FAIL idle_ack_ignored got=%h want=0", outs0);
        end
        u_if0.m1_req = 1; u_if0.m1_we = 1; u_if0.m1_adr = 16'h0200; u_if0.m1_dat_w = 16'hBEEF;
        tick();
        u_if0.m1_req = 0; u_if0.m1_dat_w = 16'h0000; u_if0.m1_adr = 16'h0000; u_if0.m1_we = 0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (u_if0.wb_cyc_o !== 1 || u_if0.wb_we_o !== 1 || u_if0.wb_adr_o !== 16'h0200 ||
                u_if0.wb_dat_o !== 16'hBEEF || u_if0.gnt !== 2'b10 || u_if0.m1_ack !== 0 ||
                u_if0.m0_ack !== 0)
                bad++;
            if (i == 3) u_if0.wb_ack_i = 1;
            tick();
        end
        u_if0.wb_ack_i = 0;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL write_stable bad_cycles=%0d want=0", bad);
        end
        checks++;
        if ({u_if0.m1_ack, u_if0.m0_ack, u_if0.m1_err, u_if0.wb_cyc_o} !== 4'b1000) begin
            failures++; $display("FAIL write_ack m1ack/m0ack/err/cyc=%b want 1000",
                                 {u_if0.m1_ack, u_if0.m0_ack, u_if0.m1_err, u_if0.wb_cyc_o});
        end
        tick();
        checks++;
        if (u_if0.m1_ack !== 1'b0 || u_if0.m0_ack !== 1'b0) begin
            failures++; $display("FAIL write_single_ack m1=%b m0=%b want 0/0", u_if0.m1_ack, u_if0.m0_ack);
        end
    endtask

    task automatic test_reset_mid_bus();
        apply_reset();
        u_if0.m0_req = 1; u_if0.m0_adr = 16'h0040;
        tick();
        u_if0.wb_ack_i = 1; u_if0.wb_dat_i = 16'h7777; reset_n = 0;
        tick();
        reset_n = 1; u_if0.wb_ack_i = 0;
        checks++;
        if (outs0 !== 73'd0) begin
            failures++; $display("FAIL reset_mid_bus got=%h want=0", outs0);
        end
        tick();
        checks++;
        if (u_if0.gnt !== 2'b01 || u_if0.wb_cyc_o !== 1'b1 || u_if0.wb_adr_o !== 16'h0040) begin
            failures++; $display("FAIL regrant gnt=%b cyc=%b adr=%h want 01/1/0040",
                                 u_if0.gnt, u_if0.wb_cyc_o, u_if0.wb_adr_o);
        end
        u_if0.m0_req = 0; u_if0.wb_ack_i = 1; u_if0.wb_dat_i = 16'h5A5A;
        tick();
        u_if0.wb_ack_i = 0;
        checks++;
        if (u_if0.m0_ack !== 1'b1 || u_if0.m0_dat_r !== 16'h5A5A) begin
            failures++; $display("FAIL regrant_ack ack=%b dat=%h want 1/5a5a", u_if0.m0_ack, u_if0.m0_dat_r);
        end
        tick();
    endtask

    task automatic test_timeout();
        int bad;
        apply_reset();
        u_if0.m0_req = 1; u_if0.m0_adr = 16'h0030;
        tick();
        u_if0.m0_req = 0;
        bad = 0;
`ifdef J1_WB_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            if (u_if0.wb_cyc_o !== 1'b1 || u_if0.m0_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL tmo_bus_hold bad_cycles=%0d want=0", bad);
        end
        tick();
        checks++;
        if ({u_if0.wb_cyc_o, u_if0.m0_ack, u_if0.m0_err, u_if0.m1_ack} !== 4'b0110 ||
            u_if0.m0_dat_r !== 16'hDEAD) begin
            failures++; $display("FAIL tmo_err cyc/ack/err/ack1=%b dat=%h want 0110/dead",
                                 {u_if0.wb_cyc_o, u_if0.m0_ack, u_if0.m0_err, u_if0.m1_ack}, u_if0.m0_dat_r);
        end
        tick();
        checks++;
        if (u_if0.m0_err !== 1'b0 || u_if0.m0_ack !== 1'b0) begin
            failures++; $display("FAIL tmo_clear ack=%b err=%b want 0/0", u_if0.m0_ack, u_if0.m0_err);
        end
`else
        for (int i = 0; i < 110; i++) begin
            if (u_if0.wb_cyc_o !== 1'b1 || u_if0.m0_ack !== 1'b0 || u_if0.m0_err !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL no_tmo_wait bad_cycles=%0d want=0", bad);
        end
        u_if0.wb_ack_i = 1; u_if0.wb_dat_i = 16'hC0DE;
        tick();
        u_if0.wb_ack_i = 0;
        checks++;
        if (u_if0.m0_ack !== 1'b1 || u_if0.m0_err !== 1'b0 || u_if0.m0_dat_r !== 16'hC0DE) begin
            failures++; $display("FAIL no_tmo_late_ack ack=%b err=%b dat=%h want 1/0/c0de",
                                 u_if0.m0_ack, u_if0.m0_err, u_if0.m0_dat_r);
        end
        tick();
`endif
    endtask

    initial begin
        reset_n = 0;
        clear_inputs();
        test_reset();
        test_read();
        test_arbitration();
        test_back_to_back_write();
        test_reset_mid_bus();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim_time=%0t limit=200000", $time);
        $fatal(1);
    end
endmodule

// File: doc/j1_wb_arbiter.md
J1_WB_ARBITER -- requirements
Module: j1_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the no-ack cycle limit for a bus cycle; legal range 1..255 (8-bit counter).
REQ-002 Parameter FIXED_PRIO, default 0, selects arbitration: 0 = round robin, 1 = m0 always wins ties.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 m0_req/m1_req  input  1 each  access request from J1 core data bus (m0) and host/loader port (m1).
REQ-006 m0_we/m1_we  input  1 each  1 = write, 0 = read.
REQ-007 m0_adr/m1_adr  input  16 each  word address.
REQ-008 m0_dat_w/m1_dat_w  input  16 each  write data.
REQ-009 m0_dat_r/m1_dat_r  output  16 each  read data, valid while matching ack = 1.
REQ-010 m0_ack/m1_ack  output  1 each  one-cycle completion pulse.
REQ-011 m0_err/m1_err  output  1 each  timeout flag, valid with ack.
REQ-012 wb_cyc_o, wb_stb_o  output  1 each  Wishbone classic cycle/strobe.
REQ-013 wb_we_o  output  1;  wb_adr_o  output  16;  wb_dat_o  output  16  Wishbone request fields.
REQ-014 wb_dat_i  input  16;  wb_ack_i  input  1  Wishbone response.
REQ-015 gnt  output  2  one-hot current owner (bit0 = m0), nonzero only in BUS and ACK.

Function
REQ-016 The FSM SHALL have states IDLE, BUS and ACK.
REQ-017 Requests are sampled only in IDLE; in IDLE with any req set, the block SHALL latch grant, we, adr and dat_w of the winner and enter BUS next edge.
REQ-018 Tie rule, FIXED_PRIO=0: grant the requester not granted last; last_grant resets to m1, so m0 wins the first tie.
REQ-019 Tie rule, FIXED_PRIO=1: m0 always wins.
REQ-020 Single requester SHALL be granted regardless of last_grant.
REQ-021 In BUS, wb_cyc_o = wb_stb_o = 1 with registered wb_we_o/wb_adr_o/wb_dat_o stable for the whole cycle.
REQ-022 On an edge where BUS and wb_ack_i = 1, the block SHALL capture wb_dat_i, deassert cyc/stb, and enter ACK.
REQ-023 In ACK, the granted mN_ack = 1 for exactly one cycle, mN_dat_r = captured data (writes: captured value, don't-care to master), mN_err = 0; the next state is IDLE.
REQ-024 Minimum latency: req sampled at edge 0, stb high cycle 1, ack to master cycle 2 if wb_ack_i high in cycle 1; next grant no earlier than edge 3.
REQ-025 Requester SHALL drop req in its ack cycle; req still high in IDLE is a new request.
REQ-026 Non-granted requester's ack/err SHALL stay 0; its req is held pending, never lost.
REQ-027 wb_ack_i outside BUS SHALL be ignored.
REQ-028 mN_dat_r SHALL hold its last value outside ACK.

Reset
REQ-029 reset_n = 0 at an edge SHALL force IDLE, last_grant = m1, timeout counter 0, and all outputs 0 (cyc, stb, we, adr, dat_o, gnt, acks, errs, dat_r) next cycle.
REQ-030 Reset SHALL dominate a simultaneous wb_ack_i or req; a cycle aborted mid-BUS produces no ack.

Configuration
REQ-031 With macro J1_WB_ARB_TIMEOUT_EN defined, an 8-bit counter cleared on BUS entry SHALL increment each BUS cycle without wb_ack_i.
REQ-032 In that build, when the counter reaches TIMEOUT_CYCLES without ack, the block SHALL drop cyc/stb and enter ACK with mN_err = 1 and mN_dat_r = 16'hDEAD.
REQ-033 In that build, ack on the timeout edge SHALL win (normal completion, err = 0).
REQ-034 Without the macro, no counter exists, BUS waits indefinitely, and m0_err/m1_err are tied 0 (ports retained).

Verification
REQ-035 m0 read adr 16'h0010, slave acks in first stb cycle with 16'h1234 -> stb cycle 1, m0_ack cycle 2 with m0_dat_r = 16'h1234, gnt = 2'b01 cycles 1-2.
REQ-036 m0 and m1 req together, held, FIXED_PRIO=0 -> grants m0, m1, m0, m1; with FIXED_PRIO=1 -> m0 every time.
REQ-037 m1 write adr 16'h0200 data 16'hBEEF, slave delays ack 3 cycles -> wb_adr_o/wb_dat_o/wb_we_o stable 4 cycles, single m1_ack, m0_ack stays 0.
REQ-038 reset_n low during BUS with wb_ack_i high same edge -> next cycle all outputs 0, no ack; next request granted normally.
REQ-039 TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks -> cyc drops after 4 BUS cycles, m0_ack = 1, m0_err = 1, m0_dat_r = 16'hDEAD; without macro cyc stays high 100+ cycles.
